// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin grant on ties, one operation in flight, response held until consumed.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [OPW-1:0]   req1_op,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_cout,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_cout,
  input  logic             rsp1_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state, next_state;
  logic             last_grant;
  logic             owner;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] x_q, y_q, res_q;
  logic [OPW-1:0]   op_q;
  logic             cin_q, cout_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;
        accept     = grant_valid;
        if (grant_valid) begin
          next_state = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if ((owner && rsp1_ready) || (!owner && rsp0_ready)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are latched at acceptance so the ALU never sees live request inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= '0;
      cin_q      <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        x_q        <= grant_id ? req1_x   : req0_x;
        y_q        <= grant_id ? req1_y   : req0_y;
        op_q       <= grant_id ? req1_op  : req0_op;
        cin_q      <= grant_id ? req1_cin : req0_cin;
      end
      if (state == EXEC) begin
        res_q  <= alu_out;
        cout_q <= alu_cout;
      end
    end
  end

  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_op    = op_q;
  assign alu_cin   = cin_q;
  assign rsp0_data = res_q;
  assign rsp0_cout = cout_q;
  assign rsp1_data = res_q;
  assign rsp1_cout = cout_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_arbiter;
  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_x, req0_y;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_x, req1_y;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_cin, alu_cout;
  logic             rsp0_valid, rsp0_cout, rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid, rsp1_cout, rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
  logic             busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   acc_q0[$];
  int   acc_q1[$];
  int   served[$];
  bit   prev_v0, prev_v1;
  bit   stop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout), .rsp1_ready(rsp1_ready),
    .busy(busy)
  );

  // Shared ALU: {cout, result}; opcodes 5..7 are treated as arbitrary extensions.
  function automatic logic [WIDTH:0] alu_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [OPW-1:0] op, input logic cin);
    logic [WIDTH:0] r;
    case (op)
      3'd0:    r = {1'b0, x & y};
      3'd1:    r = {1'b0, x | y};
      3'd2:    r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
      3'd3:    r = {1'b0, x} - {1'b0, y};
      3'd4:    r = {1'b0, x ^ y};
      3'd5:    r = {x, 1'b0};
      3'd6:    r = {1'b0, ~x};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_cout, alu_out} = alu_model(alu_x, alu_y, alu_op, alu_cin);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s at cycle %0d", name, cyc);
  endtask

  // Pushes the expected result, then holds valid until the arbiter accepts.
  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic [OPW-1:0] op, input logic cin);
    logic [WIDTH:0] r;
    exp_t e;
    bit got;
    r = alu_model(x, y, op, cin);
    e.data = r[WIDTH-1:0];
    e.cout = r[WIDTH];
    got = 1'b0;
    if (id == 0) begin
      exp_q0.push_back(e);
      req0_x = x; req0_y = y; req0_op = op; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      exp_q1.push_back(e);
      req1_x = x; req1_y = y; req1_op = op; req1_cin = cin; req1_valid = 1'b1;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    if (!got) flagFail($sformatf("accept_timeout req%0d", id));
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !busy && !req0_valid && !req1_valid;
    end
    if (!done) flagFail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic monSide(input int id, input logic acc, input logic rv, input logic rr,
                         input logic [WIDTH-1:0] d, input logic c, input bit pv);
    exp_t e;
    int   a;
    if (acc) begin
      if (id == 0) acc_q0.push_back(cyc);
      else         acc_q1.push_back(cyc);
    end
    if (rv && !pv) begin
      if ((id == 0 && acc_q0.size() == 0) || (id == 1 && acc_q1.size() == 0)) begin
        flagFail($sformatf("unexpected_rsp%0d valid=1 required 0", id));
      end else begin
        a = (id == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
        checkOutput($sformatf("latency%0d", id), 32'(cyc - a), 32'd2);
      end
    end
    if (rv && rr) begin
      if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
        flagFail($sformatf("rsp%0d_handshake_without_request", id));
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        checkOutput($sformatf("rsp%0d_data", id), 32'(d), 32'(e.data));
        checkOutput($sformatf("rsp%0d_cout", id), 32'(c), 32'(e.cout));
        served.push_back(id);
      end
    end
  endtask

  // Monitor: samples at the falling edge, matches responses against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v0 = 1'b0;
        prev_v1 = 1'b0;
      end else begin
        if (rsp0_valid || rsp1_valid) checkOutput("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
        monSide(0, req0_valid && req0_ready, rsp0_valid, rsp0_ready, rsp0_data, rsp0_cout, prev_v0);
        monSide(1, req1_valid && req1_ready, rsp1_valid, rsp1_ready, rsp1_data, rsp1_cout, prev_v1);
        prev_v0 = rsp0_valid;
        prev_v1 = rsp1_valid;
      end
    end
  end

  task automatic randDriver(input int id);
    int gap;
    logic [WIDTH-1:0] x;
    for (int n = 0; n < 30; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      x = ($urandom_range(0, 5) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
      applyStimulus(id, x, WIDTH'($urandom), OPW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_x = '0; req0_y = '0; req0_op = '0; req0_cin = 0;
    req1_valid = 0; req1_x = '0; req1_y = '0; req1_op = '0; req1_cin = 0;
    rsp0_ready = 0; rsp1_ready = 0; stop = 0;
    #1;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 0);
    checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 0);
    checkOutput("reset_alu_x", 32'(alu_x), 0);
    checkOutput("reset_alu_op", 32'(alu_op), 0);
    checkOutput("reset_req0_ready", 32'(req0_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] tie arbitration after reset");
    rsp0_ready = 1; rsp1_ready = 1;
    served.delete();
    fork
      begin
        applyStimulus(0, 16'h0011, 16'h0022, 3'd2, 1'b0);
        applyStimulus(0, 16'h00F0, 16'h0F0F, 3'd1, 1'b0);
      end
      begin
        applyStimulus(1, 16'h1000, 16'h0001, 3'd3, 1'b0);
        applyStimulus(1, 16'hAAAA, 16'h5555, 3'd4, 1'b1);
      end
    join_none
    @(negedge clk);
    checkOutput("tie_first_req0_ready", 32'(req0_ready), 1);
    checkOutput("tie_first_req1_ready", 32'(req1_ready), 0);
    waitIdle();
    checkOutput("tie_served_count", 32'(served.size()), 4);
    for (int i = 0; i < served.size() && i < 4; i++)
      checkOutput($sformatf("tie_order_%0d", i), 32'(served[i]), 32'(i % 2));

    $display("[TB] single add");
    applyStimulus(0, 16'h0003, 16'h0004, 3'b010, 1'b0);
    checkOutput("add_alu_x", 32'(alu_x), 32'h3);
    checkOutput("add_alu_y", 32'(alu_y), 32'h4);
    checkOutput("add_alu_op", 32'(alu_op), 32'h2);
    checkOutput("add_exec_rsp0_valid", 32'(rsp0_valid), 0);
    checkOutput("add_exec_busy", 32'(busy), 1);
    @(posedge clk); #1;
    checkOutput("add_rsp0_valid", 32'(rsp0_valid), 1);
    checkOutput("add_rsp0_data", 32'(rsp0_data), 32'h7);
    @(posedge clk); #1;
    checkOutput("add_rsp0_valid_drop", 32'(rsp0_valid), 0);
    checkOutput("add_idle_busy", 32'(busy), 0);
    waitIdle();

    $display("[TB] carry");
    applyStimulus(1, 16'hFFFF, 16'h0001, 3'b010, 1'b0);
    @(posedge clk); #1;
    checkOutput("carry_rsp1_valid", 32'(rsp1_valid), 1);
    checkOutput("carry_rsp1_data", 32'(rsp1_data), 32'h0);
    checkOutput("carry_rsp1_cout", 32'(rsp1_cout), 1);
    waitIdle();

    $display("[TB] response backpressure");
    rsp1_ready = 0;
    applyStimulus(1, 16'h1234, 16'h4321, 3'b010, 1'b1);
    fork
      applyStimulus(0, 16'h0F00, 16'h00FF, 3'd1, 1'b0);
    join_none
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_rsp1_valid", 32'(rsp1_valid), 1);
      checkOutput("bp_rsp1_data", 32'(rsp1_data), 32'h5556);
      checkOutput("bp_busy", 32'(busy), 1);
      checkOutput("bp_req0_ready", 32'(req0_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp1_ready = 1;
    @(posedge clk); #1;
    checkOutput("bp_release_rsp1_valid", 32'(rsp1_valid), 0);
    checkOutput("bp_release_busy", 32'(busy), 0);
    waitIdle();

    $display("[TB] isolation of the idle requester");
    rsp0_ready = 0;
    applyStimulus(0, 16'h1234, 16'h0101, 3'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      req1_x = WIDTH'($urandom);
      req1_y = WIDTH'($urandom);
      req1_op = OPW'($urandom_range(0, 7));
      req1_valid = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      checkOutput("iso_alu_x", 32'(alu_x), 32'h1234);
      checkOutput("iso_alu_y", 32'(alu_y), 32'h0101);
      checkOutput("iso_req1_ready", 32'(req1_ready), 0);
      if (i > 0) checkOutput("iso_rsp0_data", 32'(rsp0_data), 32'h1335);
      @(posedge clk); #1;
    end
    rsp0_ready = 1;
    waitIdle();

    $display("[TB] reset during EXEC");
    applyStimulus(0, 16'h0005, 16'h0006, 3'b010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_exec_busy", 32'(busy), 0);
    checkOutput("rst_exec_rsp0_valid", 32'(rsp0_valid), 0);
    checkOutput("rst_exec_alu_x", 32'(alu_x), 0);
    exp_q0.delete();
    acc_q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 16'h0009, 16'h0008, 3'b010, 1'b1);
    waitIdle();

    $display("[TB] randomized traffic");
    fork
      begin
        fork
          randDriver(0);
          randDriver(1);
        join
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp0_ready = 1; rsp1_ready = 1;
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
